e_clk_window_gen: RTL and testbench
===================================

Name: e_clk_window_gen

Overview:
Parametrised successor to the single-channel E-clock buffer-enable delay. Synchronises the 6809 E clock into the PLL domain and drives NCH independent buffer-enable windows. Each window opens a per-channel LEAD delay after E rises and closes a per-channel TRAIL delay after E falls. Sits between the 6809 bus pins and the data/address buffer OE pins on the board glue logic.

Parameters:
NCH, 4, number of output-enable channels (1..8)
CNT_W, 4, width of each per-channel lead/trail delay count
SYNC_STAGES, 2, flops in the E input synchroniser (>=2)
OE_POL, {NCH{1'b1}}, per-channel output polarity; bit=1 means active-high, bit=0 means active-low
WDT_CYCLES, 1024, watchdog timeout in i_clk cycles (used only with the optional feature)

Ports:
i_clk  in  1  fast PLL clock (e.g. 100 MHz)
i_rst_n  in  1  asynchronous active-low reset
i_e_clk  in  1  raw 6809 E clock (asynchronous)
i_ch_en  in  NCH  per-channel enable; 0 forces the channel idle
i_lead  in  NCH*CNT_W  per-channel rise delay; channel c uses bits [c*CNT_W +: CNT_W]
i_trail  in  NCH*CNT_W  per-channel fall delay; same packing as i_lead
o_oe  out  NCH  per-channel buffer enable, polarity set by OE_POL
o_e_sync  out  1  synchronised E (last synchroniser stage)
o_runt  out  1  one-cycle pulse when any enabled channel aborts a LEAD count
o_e_lost  out  1  watchdog flag (optional feature only; tied 0 otherwise)

Behaviour:
- Reset (async assert, sync release): synchroniser flops and e_prev = 0; all channels in IDLE; o_oe[c] = ~OE_POL[c] (inactive); o_runt = 0; o_e_lost = 0.
- Edge detect on the synchronised signal: rise = e_s & ~e_prev; fall = ~e_s & e_prev. Each is a one-cycle pulse.
- Latency: o_oe[c] goes active exactly SYNC_STAGES+1+LEAD edges after the first i_clk edge that samples i_e_clk high. It goes inactive exactly SYNC_STAGES+1+TRAIL edges after the first edge that samples i_e_clk low. LEAD=0 or TRAIL=0 gives the minimum latency.
- Delay values are captured into the channel counter on the edge pulse: i_lead on rise, i_trail on fall. Changing i_lead/i_trail mid-count does not affect the count in progress.
- Per-channel FSM. Internal oe is active in ACTIVE and TRAIL only.
  - IDLE: on rise, if lead==0 go to ACTIVE, else load cnt=lead-1 and go to LEAD.
  - LEAD: decrement cnt; at cnt==0 go to ACTIVE. A fall while in LEAD goes to IDLE, leaves the window unopened and pulses o_runt.
  - ACTIVE: on fall, if trail==0 go to IDLE, else load cnt=trail-1 and go to TRAIL.
  - TRAIL: decrement cnt; at cnt==0 go to IDLE. A rise while in TRAIL goes straight to ACTIVE, merging the windows; the output stays active with no gap.
- Counter saturates at 0 and never wraps below zero.
- o_oe[c] is registered: o_oe[c] = internal_oe ^ ~OE_POL[c].
- i_ch_en[c]=0: the channel goes to IDLE on the next edge and its output goes inactive there. The channel is re-armed only by a fresh rise after i_ch_en[c] returns to 1. A rise coincident with re-enable is honoured.
- o_runt is the OR of the abort conditions of all enabled channels, registered.
- o_e_sync = e_s. It is not delayed by the output register.

Optional Feature:
Macro: E_CLK_WATCHDOG_EN.
- Defined: a counter of ceil(log2(WDT_CYCLES+1)) bits clears on any rise or fall and otherwise increments, saturating.
  - When it reaches WDT_CYCLES, o_e_lost=1 and all channels are forced to IDLE with outputs inactive.
  - o_e_lost clears on the next detected edge; normal operation resumes from that edge.
- Undefined: no watchdog logic; o_e_lost is driven constant 0.

Decomposition:
- Package e_clk_pkg:
  - state enum ST_IDLE/ST_LEAD/ST_ACTIVE/ST_TRAIL (2 bits)
  - localparam for watchdog counter width
  - function to extract channel slice from a packed bus
- Sub-module e_clk_window_chan: one FSM, its counter and its output register. Instantiated NCH times by a generate loop.
- The top level owns the synchroniser, edge detect, runt OR and watchdog.

Test Plan:
- Config NCH=2, lead={3,0}, trail={2,1}, POL=2'b01, E period 100 cycles at 50% duty. Required: ch0 rises 6 edges after E rise and falls 5 edges after E fall. ch1 (active-low) goes low 3 edges after E rise and returns high 4 edges after E fall.
- Runt: lead=8, E high for only 5 cycles. Required: o_oe stays inactive and o_runt pulses exactly once.
- Merge: trail=10, E low for only 4 cycles. Required: o_oe stays continuously active through the next high phase.
- i_ch_en[0] dropped mid-ACTIVE. Required: o_oe[0] inactive on the next edge and no reassertion until enable returns and a new rise arrives. i_lead changed mid-LEAD: the current window keeps its old timing.
- Reset asserted mid-TRAIL. Required: all o_oe go inactive asynchronously. After release, no window opens until a new E rise.
- With E_CLK_WATCHDOG_EN and WDT_CYCLES=50: hold E high for 60 cycles. Required: o_e_lost=1 at cycle 50 and o_oe inactive. The next E fall clears o_e_lost.

Source files
------------

// File: rtl/e_clk_pkg.sv
// -----------------------------------------------------------------------------
// e_clk_pkg
// Shared types and helpers for the E-clock buffer-enable window generator.
//   state_t     : per-channel window FSM encoding
//   wdt_width() : bit width of a saturating counter that must reach 'cycles'
//   chan_slice(): extracts channel c's field from a packed per-channel bus
// -----------------------------------------------------------------------------
package e_clk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LEAD   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_TRAIL  = 2'd3
    } state_t;

    localparam int unsigned WDT_CYCLES_DEF = 32'd1024;
    localparam int unsigned WDT_W_DEF      = $clog2(WDT_CYCLES_DEF + 32'd1);

    // Upper bounds for the slice helper: 8 channels of at most 16-bit counts.
    localparam int unsigned MAX_CNT_W = 32'd16;
    localparam int unsigned MAX_BUS_W = 32'd128;

    function automatic int unsigned wdt_width(input int unsigned cycles);
        return $clog2(cycles + 32'd1);
    endfunction

    function automatic logic [MAX_CNT_W-1:0] chan_slice(
        input logic [MAX_BUS_W-1:0] bus,
        input int unsigned          c,
        input int unsigned          w
    );
        logic [MAX_BUS_W-1:0] shifted;
        logic [MAX_CNT_W-1:0] mask;
        shifted = bus >> (c * w);
        mask    = MAX_CNT_W'((32'd1 << w) - 32'd1);
        return shifted[MAX_CNT_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/e_clk_window_chan.sv
// -----------------------------------------------------------------------------
// e_clk_window_chan
// One buffer-enable window: FSM, delay counter and registered output.
// The window opens LEAD cycles after a synchronised E rise and closes TRAIL
// cycles after a synchronised E fall.
//   i_clk, i_rst_n   : clock, async active-low reset
//   i_en             : channel enable (0 forces IDLE and inactive output)
//   i_rise, i_fall   : one-cycle edge pulses of the synchronised E
//   i_lead, i_trail  : delay counts, captured on the matching edge pulse
//   o_oe             : registered buffer enable, polarity from OE_POL_BIT
//   o_abort          : combinational, a fall arrived while still in LEAD
// -----------------------------------------------------------------------------
module e_clk_window_chan
    import e_clk_pkg::*;
#(
    parameter int   CNT_W      = 4,
    parameter logic OE_POL_BIT = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_rise,
    input  logic             i_fall,
    input  logic [CNT_W-1:0] i_lead,
    input  logic [CNT_W-1:0] i_trail,
    output logic             o_oe,
    output logic             o_abort
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_win;
    logic               r_oe;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

    assign w_win   = (r_state == ST_ACTIVE) || (r_state == ST_TRAIL);
    assign o_abort = i_en & i_fall & (r_state == ST_LEAD);
    assign o_oe    = r_oe;

    // Next-state and counter logic; a rise beats an expiring TRAIL (merge),
    // a fall beats an expiring LEAD (runt).
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (!i_en) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_rise) begin
                        if (i_lead == CNT_ZERO) begin
                            w_state_nxt = ST_ACTIVE;
                        end else begin
                            w_state_nxt = ST_LEAD;
                            w_cnt_nxt   = i_lead - CNT_ONE;
                        end
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_LEAD: begin
                    if (i_fall) begin
                        w_state_nxt = ST_IDLE;
                    end else if (r_cnt == CNT_ZERO) begin
                        w_state_nxt = ST_ACTIVE;
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_ONE;
                    end
                end
                ST_ACTIVE: begin
                    if (i_fall) begin
                        if (i_trail == CNT_ZERO) begin
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_state_nxt = ST_TRAIL;
                            w_cnt_nxt   = i_trail - CNT_ONE;
                        end
                    end else begin
                        w_state_nxt = ST_ACTIVE;
                    end
                end
                ST_TRAIL: begin
                    if (i_rise) begin
                        w_state_nxt = ST_ACTIVE;
                    end else if (r_cnt == CNT_ZERO) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_ONE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State, counter and output register; a disabled channel drops its
    // output on the same edge that sends the FSM to IDLE.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= CNT_ZERO;
            r_oe    <= ~OE_POL_BIT;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_oe    <= (w_win & i_en) ^ ~OE_POL_BIT;
        end
    end

endmodule

// File: rtl/e_clk_window_gen.sv
// -----------------------------------------------------------------------------
// e_clk_window_gen
// Synchronises the 6809 E clock into the PLL domain and drives NCH
// independent buffer-enable windows (see e_clk_window_chan).
// Optional watchdog enabled by defining E_CLK_WATCHDOG_EN.
//   i_clk     : PLL clock
//   i_rst_n   : async active-low reset
//   i_e_clk   : raw E clock (asynchronous)
//   i_ch_en   : per-channel enable
//   i_lead    : per-channel rise delay, channel c at [c*CNT_W +: CNT_W]
//   i_trail   : per-channel fall delay, same packing
//   o_oe      : per-channel buffer enable, polarity from OE_POL
//   o_e_sync  : synchronised E (last synchroniser stage)
//   o_runt    : one-cycle pulse when an enabled channel aborts a LEAD count
//   o_e_lost  : watchdog flag (constant 0 without E_CLK_WATCHDOG_EN)
// -----------------------------------------------------------------------------
module e_clk_window_gen
    import e_clk_pkg::*;
#(
    parameter int             NCH         = 4,
    parameter int             CNT_W       = 4,
    parameter int             SYNC_STAGES = 2,
    parameter logic [NCH-1:0] OE_POL      = {NCH{1'b1}},
    parameter int             WDT_CYCLES  = WDT_CYCLES_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_e_clk,
    input  logic [NCH-1:0]       i_ch_en,
    input  logic [NCH*CNT_W-1:0] i_lead,
    input  logic [NCH*CNT_W-1:0] i_trail,
    output logic [NCH-1:0]       o_oe,
    output logic                 o_e_sync,
    output logic                 o_runt,
    output logic                 o_e_lost
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_e_prev;
    logic                   w_e_s;
    logic                   w_rise;
    logic                   w_fall;
    logic                   w_kill;
    logic [NCH-1:0]         w_ch_en;
    logic [NCH-1:0]         w_abort;
    logic                   r_runt;
    logic [MAX_BUS_W-1:0]   w_lead_bus;
    logic [MAX_BUS_W-1:0]   w_trail_bus;

    assign w_e_s    = r_sync[SYNC_STAGES-1];
    assign w_rise   = w_e_s & ~r_e_prev;
    assign w_fall   = ~w_e_s & r_e_prev;
    assign o_e_sync = w_e_s;
    assign o_runt   = r_runt;
    assign w_ch_en  = i_ch_en & ~{NCH{w_kill}};

    assign w_lead_bus  = MAX_BUS_W'(i_lead);
    assign w_trail_bus = MAX_BUS_W'(i_trail);

    // E synchroniser, previous-value flop for edge detection and runt flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync   <= {SYNC_STAGES{1'b0}};
            r_e_prev <= 1'b0;
            r_runt   <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], i_e_clk};
            r_e_prev <= w_e_s;
            r_runt   <= |w_abort;
        end
    end

`ifdef E_CLK_WATCHDOG_EN
    localparam int unsigned      WDT_W   = wdt_width(WDT_CYCLES);
    localparam logic [WDT_W-1:0] WDT_MAX = WDT_W'(WDT_CYCLES);

    logic [WDT_W-1:0] r_wdt;
    logic             r_e_lost;
    logic             w_edge;

    assign w_edge   = w_rise | w_fall;
    // A detected edge wins over an expired count so that edge restarts normal operation.
    assign w_kill   = (r_wdt == WDT_MAX) & ~w_edge;
    assign o_e_lost = r_e_lost;

    // Saturating count of cycles since the last E edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wdt    <= {WDT_W{1'b0}};
            r_e_lost <= 1'b0;
        end else begin
            if (w_edge) begin
                r_wdt <= {WDT_W{1'b0}};
            end else if (r_wdt == WDT_MAX) begin
                r_wdt <= r_wdt;
            end else begin
                r_wdt <= r_wdt + WDT_W'(1'b1);
            end
            r_e_lost <= w_kill;
        end
    end
`else
    assign w_kill   = 1'b0;
    assign o_e_lost = 1'b0;
`endif

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [CNT_W-1:0] w_lead_c;
        logic [CNT_W-1:0] w_trail_c;

        assign w_lead_c  = CNT_W'(chan_slice(w_lead_bus, c, CNT_W));
        assign w_trail_c = CNT_W'(chan_slice(w_trail_bus, c, CNT_W));

        e_clk_window_chan #(
            .CNT_W      (CNT_W),
            .OE_POL_BIT (OE_POL[c])
        ) u_chan (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_en    (w_ch_en[c]),
            .i_rise  (w_rise),
            .i_fall  (w_fall),
            .i_lead  (w_lead_c),
            .i_trail (w_trail_c),
            .o_oe    (o_oe[c]),
            .o_abort (w_abort[c])
        );
    end

endmodule

// File: tb/tb_e_clk_window_gen.sv
// -----------------------------------------------------------------------------
// tb_e_clk_window_gen
// Self-checking bench for e_clk_window_gen (NCH=2, POL=2'b01). A timestamp
// model predicts, per channel, the absolute edge at which each window opens
// and closes, from the input edge times and the lead/trail values.
// -----------------------------------------------------------------------------
module tb_e_clk_window_gen;

    localparam int             NCH   = 2;
    localparam int             CNT_W = 4;
    localparam int             SS    = 2;
    localparam logic [NCH-1:0] POL   = 2'b01;
    localparam int             WDT   = 50;
    localparam longint         INF   = 64'd1000000000;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 e_in;
    logic [NCH-1:0]       ch_en;
    logic [NCH*CNT_W-1:0] lead;
    logic [NCH*CNT_W-1:0] trail;
    logic [NCH-1:0]       o_oe;
    logic                 o_e_sync;
    logic                 o_runt;
    logic                 o_e_lost;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    e_clk_window_gen #(
        .NCH         (NCH),
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SS),
        .OE_POL      (POL),
        .WDT_CYCLES  (WDT)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_e_clk  (e_in),
        .i_ch_en  (ch_en),
        .i_lead   (lead),
        .i_trail  (trail),
        .o_oe     (o_oe),
        .o_e_sync (o_e_sync),
        .o_runt   (o_runt),
        .o_e_lost (o_e_lost)
    );

    // ---------------- reference model ----------------
    bit             hist[$];      // E samples, hist[0] = newest edge
    longint         k;            // edge index since reset release
    longint         last_det;
    bit             win[NCH];
    longint         open_t[NCH];
    longint         close_t[NCH];
    logic [NCH-1:0] exp_oe;
    logic           exp_runt;
    logic           exp_lost;
    logic           exp_sync;

    function automatic void model_reset();
        hist.delete();
        for (int i = 0; i < SS + 2; i++) hist.push_back(1'b0);
        k        = 0;
        last_det = 0;
        for (int c = 0; c < NCH; c++) begin
            win[c]     = 1'b0;
            open_t[c]  = INF;
            close_t[c] = INF;
        end
        exp_oe   = ~POL;
        exp_runt = 1'b0;
        exp_lost = 1'b0;
        exp_sync = 1'b0;
    endfunction

    // The synchronised E seen at edge k is the pin value sampled SS edges earlier.
    function automatic void model_step();
        bit rise, fall, kill, en;
        k++;
        hist.push_front(e_in);
        void'(hist.pop_back());
        rise     = hist[SS] && !hist[SS+1];
        fall     = !hist[SS] && hist[SS+1];
        exp_sync = hist[SS-1];
        kill     = 1'b0;
`ifdef E_CLK_WATCHDOG_EN
        if (rise || fall) last_det = k;
        else if (k - last_det >= WDT + 1) kill = 1'b1;
`endif
        exp_lost = kill;
        exp_runt = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            en = ch_en[c] && !kill;
            if (!en) begin
                win[c] = 1'b0;
            end else if (rise) begin
                if (!win[c] || close_t[c] <= k) begin
                    win[c]     = 1'b1;
                    open_t[c]  = k + 1 + longint'(lead[c*CNT_W +: CNT_W]);
                    close_t[c] = INF;
                end else if (close_t[c] != INF) begin
                    close_t[c] = INF;          // E came back before the close: merge
                end
            end else if (fall && win[c] && close_t[c] > k) begin
                if (k < open_t[c]) begin
                    win[c]   = 1'b0;           // never opened: runt
                    exp_runt = 1'b1;
                end else if (close_t[c] == INF) begin
                    close_t[c] = k + 1 + longint'(trail[c*CNT_W +: CNT_W]);
                end
            end
            exp_oe[c] = (win[c] && open_t[c] <= k && k < close_t[c]) ^ ~POL[c];
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; e_in = 1'b0; ch_en = 2'b11; lead = '0; trail = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (o_oe !== ~POL) begin n_fail++; $display("FAIL reset_oe: got %b want %b", o_oe, ~POL); end
        n_checks++; if (o_runt !== 1'b0) begin n_fail++; $display("FAIL reset_runt: got %b want 0", o_runt); end
        n_checks++; if (o_e_lost !== 1'b0) begin n_fail++; $display("FAIL reset_lost: got %b want 0", o_e_lost); end
        n_checks++; if (o_e_sync !== 1'b0) begin n_fail++; $display("FAIL reset_sync: got %b want 0", o_e_sync); end
        @(negedge clk); rst_n = 1'b1;
        repeat (5) begin
            tick();
            n_checks++; if (o_oe !== exp_oe) begin n_fail++; $display("FAIL post_reset_oe: got %b want %b", o_oe, exp_oe); end
        end
    endtask

    task automatic test_basic_timing();
        int t0r, t1r, t0f, t1f;
        lead = {4'd0, 4'd3}; trail = {4'd1, 4'd2}; ch_en = 2'b11;
        e_in = 1'b0;
        repeat (10) tick();
        t0r = -1; t1r = -1; t0f = -1; t1f = -1;
        e_in = 1'b1; tick();                       // sampling edge of the rise
        for (int n = 1; n < 50; n++) begin
            tick();
            if (t0r < 0 && o_oe[0] === 1'b1) t0r = n;
            if (t1r < 0 && o_oe[1] === 1'b0) t1r = n;
            n_checks++; if (o_oe !== exp_oe) begin n_fail++; $display("FAIL basic_high_oe: got %b want %b edge %0d", o_oe, exp_oe, k); end
        end
        e_in = 1'b0; tick();                       // sampling edge of the fall
        for (int n = 1; n < 50; n++) begin
            tick();
            if (t0f < 0 && o_oe[0] === 1'b0) t0f = n;
            if (t1f < 0 && o_oe[1] === 1'b1) t1f = n;
            n_checks++; if (o_oe !== exp_oe) begin n_fail++; $display("FAIL basic_low_oe: got %b want %b edge %0d", o_oe, exp_oe, k); end
        end
        n_checks++; if (t0r !== 6) begin n_fail++; $display("FAIL ch0_open_latency: got %0d want 6", t0r); end
        n_checks++; if (t1r !== 3) begin n_fail++; $display("FAIL ch1_open_latency: got %0d want 3", t1r); end
        n_checks++; if (t0f !== 5) begin n_fail++; $display("FAIL ch0_close_latency: got %0d want 5", t0f); end
        n_checks++; if (t1f !== 4) begin n_fail++; $display("FAIL ch1_close_latency: got %0d want 4", t1f); end
    endtask

    task automatic test_runt();
        int pulses, bad;
        lead = {4'd8, 4'd8}; trail = {4'd2, 4'd2}; ch_en = 2'b11;
        pulses = 0; bad = 0;
        e_in = 1'b0; repeat (20) tick();
        for (int n = 0; n < 35; n++) begin
            e_in = (n < 5) ? 1'b1 : 1'b0;
            tick();
            if (o_runt === 1'b1) pulses++;
            if (o_oe !== ~POL) bad++;
            n_checks++; if (o_runt !== exp_runt) begin n_fail++; $display("FAIL runt_model: got %b want %b edge %0d", o_runt, exp_runt, k); end
        end
        n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL runt_pulses: got %0d want 1", pulses); end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL runt_oe_opened: got %0d active cycles want 0", bad); end
    endtask

    task automatic test_merge();
        int gaps;
        bit opened;
        lead = {4'd0, 4'd0}; trail = {4'd10, 4'd10}; ch_en = 2'b11;
        gaps = 0; opened = 1'b0;
        e_in = 1'b0; repeat (20) tick();
        for (int n = 0; n < 64; n++) begin
            e_in = (n < 30 || n >= 34) ? 1'b1 : 1'b0;
            tick();
            if (o_oe === POL) opened = 1'b1;
            else if (opened) gaps++;
            n_checks++; if (o_oe !== exp_oe) begin n_fail++; $display("FAIL merge_oe: got %b want %b edge %0d", o_oe, exp_oe, k); end
        end
        n_checks++; if (!(opened && gaps == 0)) begin n_fail++; $display("FAIL merge_gap: opened=%0d gaps=%0d want opened=1 gaps=0", opened, gaps); end
        e_in = 1'b0; repeat (30) tick();
    endtask

    task automatic test_ch_en();
        int bad, t_open;
        lead = {4'd0, 4'd0}; trail = {4'd0, 4'd0}; ch_en = 2'b11;
        bad = 0; t_open = -1;
        e_in = 1'b0; repeat (20) tick();
        e_in = 1'b1; repeat (10) tick();
        ch_en = 2'b10; tick();
        n_checks++; if (o_oe[0] !== 1'b0) begin n_fail++; $display("FAIL en_drop_next_edge: got %b want 0", o_oe[0]); end
        repeat (10) begin tick(); if (o_oe[0] !== 1'b0) bad++; end
        ch_en = 2'b11;
        repeat (10) begin tick(); if (o_oe[0] !== 1'b0) bad++; end
        e_in = 1'b0;
        repeat (20) begin tick(); if (o_oe[0] !== 1'b0) bad++; end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL en_no_reassert: got %0d active cycles want 0", bad); end
        e_in = 1'b1; tick();
        for (int n = 1; n < 10; n++) begin
            tick();
            if (t_open < 0 && o_oe[0] === 1'b1) t_open = n;
            n_checks++; if (o_oe !== exp_oe) begin n_fail++; $display("FAIL en_rearm_oe: got %b want %b edge %0d", o_oe, exp_oe, k); end
        end
        n_checks++; if (t_open !== 3) begin n_fail++; $display("FAIL en_rearm_latency: got %0d want 3", t_open); end
        e_in = 1'b0; repeat (20) tick();
    endtask

    task automatic test_lead_change();
        int t_open;
        lead = {4'd0, 4'd6}; trail = {4'd0, 4'd0}; ch_en = 2'b11;
        t_open = -1;
        e_in = 1'b0; repeat (10) tick();
        e_in = 1'b1; tick();
        for (int n = 1; n < 20; n++) begin
            if (n == 4) lead = {4'd0, 4'd1};
            tick();
            if (t_open < 0 && o_oe[0] === 1'b1) t_open = n;
        end
        n_checks++; if (t_open !== 9) begin n_fail++; $display("FAIL lead_change_latency: got %0d want 9", t_open); end
        e_in = 1'b0; repeat (20) tick();
    endtask

    task automatic test_reset_mid_trail();
        lead = {4'd0, 4'd0}; trail = {4'd15, 4'd15}; ch_en = 2'b11;
        e_in = 1'b1; repeat (30) tick();
        e_in = 1'b0; repeat (6) tick();
        n_checks++; if (o_oe !== POL) begin n_fail++; $display("FAIL trail_active: got %b want %b", o_oe, POL); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (o_oe !== ~POL) begin n_fail++; $display("FAIL async_reset_oe: got %b want %b", o_oe, ~POL); end
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        repeat (30) begin
            tick();
            n_checks++; if (o_oe !== ~POL) begin n_fail++; $display("FAIL post_reset_idle: got %b want %b", o_oe, ~POL); end
        end
        e_in = 1'b1;
        repeat (10) begin
            tick();
            n_checks++; if (o_oe !== exp_oe) begin n_fail++; $display("FAIL post_reset_rise: got %b want %b edge %0d", o_oe, exp_oe, k); end
        end
        e_in = 1'b0; repeat (20) tick();
    endtask

    task automatic test_random();
        int len;
        for (int p = 0; p < 120; p++) begin
            e_in = ~e_in;
            len  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(55, 70)) : int'($urandom_range(1, 40));
            for (int n = 0; n < len; n++) begin
                if ($urandom_range(0, 7) == 0) lead  = NCH*CNT_W'($urandom);
                if ($urandom_range(0, 7) == 0) trail = NCH*CNT_W'($urandom);
                for (int c = 0; c < NCH; c++)
                    if ($urandom_range(0, 59) == 0) ch_en[c] = ~ch_en[c];
                tick();
                n_checks++; if (o_oe !== exp_oe) begin n_fail++; $display("FAIL rand_oe: got %b want %b edge %0d", o_oe, exp_oe, k); end
                n_checks++; if (o_runt !== exp_runt) begin n_fail++; $display("FAIL rand_runt: got %b want %b edge %0d", o_runt, exp_runt, k); end
                n_checks++; if (o_e_sync !== exp_sync) begin n_fail++; $display("FAIL rand_sync: got %b want %b edge %0d", o_e_sync, exp_sync, k); end
                n_checks++; if (o_e_lost !== exp_lost) begin n_fail++; $display("FAIL rand_lost: got %b want %b edge %0d", o_e_lost, exp_lost, k); end
            end
        end
        ch_en = 2'b11;
        e_in = 1'b0; repeat (20) tick();
    endtask

`ifdef E_CLK_WATCHDOG_EN
    task automatic test_watchdog();
        lead = {4'd0, 4'd0}; trail = {4'd0, 4'd0}; ch_en = 2'b11;
        e_in = 1'b0; repeat (20) tick();
        e_in = 1'b1;
        repeat (60) begin
            tick();
            n_checks++; if (o_e_lost !== exp_lost) begin n_fail++; $display("FAIL wdt_lost_model: got %b want %b edge %0d", o_e_lost, exp_lost, k); end
        end
        n_checks++; if (o_e_lost !== 1'b1) begin n_fail++; $display("FAIL wdt_lost_set: got %b want 1", o_e_lost); end
        n_checks++; if (o_oe !== ~POL) begin n_fail++; $display("FAIL wdt_oe_inactive: got %b want %b", o_oe, ~POL); end
        e_in = 1'b0;
        repeat (SS + 1) tick();
        n_checks++; if (o_e_lost !== 1'b0) begin n_fail++; $display("FAIL wdt_lost_clear: got %b want 0", o_e_lost); end
        repeat (10) tick();
    endtask
`endif

    initial begin
        test_reset();
        test_basic_timing();
        test_runt();
        test_merge();
        test_ch_en();
        test_lead_change();
        test_reset_mid_trail();
`ifdef E_CLK_WATCHDOG_EN
        test_watchdog();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
